// File: rtl/mux_rr_scanner_if.sv
// Channel-side (select/grant/mux result) and downstream valid/ready bundle
// for the round-robin mux scanner.
interface mux_rr_scanner_if #(
  parameter int DATA_W = 4,
  parameter int NCH    = 6
);
  logic [NCH-1:0]    req;
  logic [DATA_W-1:0] mux_data;
  logic [2:0]        sel;
  logic [NCH-1:0]    grant;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        out_chan;
  logic              out_ready;

  modport slave (
    input  req, mux_data, out_ready,
    output sel, grant, out_valid, out_data, out_chan
  );

  modport master (
    output req, mux_data, out_ready,
    input  sel, grant, out_valid, out_data, out_chan
  );
endinterface

// File: rtl/mux_rr_scanner.sv
// Round-robin scanner: picks a requesting channel, drives the external mux
// select for one cycle, then holds the sampled word on a valid/ready output.
module mux_rr_scanner #(
  parameter int DATA_W = 4,
  parameter int NCH    = 6
) (
  input logic             clk,
  input logic             reset,
  mux_rr_scanner_if.slave bus
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEL   = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [3:0] NCH_W    = 4'(NCH);
  localparam logic [2:0] LAST_RST = 3'(NCH - 1);

  logic [1:0]        state_reg, state_next;
  logic [2:0]        last_reg, last_next;
  logic [2:0]        sel_reg, sel_next;
  logic [NCH-1:0]    grant_reg, grant_next;
  logic              valid_reg, valid_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic [2:0]        chan_reg, chan_next;

  logic [2:0]     cand_idx [NCH];
  logic [NCH-1:0] cand_req;
  logic           have_win;
  logic [2:0]     win_idx;
  logic [NCH-1:0] win_onehot;
  logic           take;

  // Candidate gi is the channel gi+1 places after the last winner, wrapped at NCH.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_cand
      logic [3:0] sum;
      assign sum          = {1'b0, last_reg} + 4'(gi + 1);
      assign cand_idx[gi] = (sum >= NCH_W) ? 3'(sum - NCH_W) : sum[2:0];
      assign cand_req[gi] = bus.req[cand_idx[gi]];
    end
  endgenerate

  // Walk from the far end so the nearest requesting candidate overwrites last.
  always_comb begin
    have_win   = |bus.req;
    win_idx    = '0;
    win_onehot = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (cand_req[k]) win_idx = cand_idx[k];
    end
    win_onehot[win_idx] = 1'b1;
  end

  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    sel_next   = sel_reg;
    grant_next = '0;
    valid_next = valid_reg;
    data_next  = data_reg;
    chan_next  = chan_reg;
    take       = 1'b0;
    case (state_reg)
      ST_IDLE: take = have_win;
      ST_SEL: begin
        data_next  = bus.mux_data;
        chan_next  = sel_reg;
        valid_next = 1'b1;
        state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          valid_next = 1'b0;
          state_next = ST_IDLE;
          take       = have_win;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // A new arbitration can start from IDLE or straight out of a HOLD handshake.
    if (take) begin
      sel_next   = win_idx;
      last_next  = win_idx;
      grant_next = win_onehot;
      state_next = ST_SEL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      last_reg  <= LAST_RST;
      sel_reg   <= '0;
      grant_reg <= '0;
      valid_reg <= 1'b0;
      data_reg  <= '0;
      chan_reg  <= '0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      sel_reg   <= sel_next;
      grant_reg <= grant_next;
      valid_reg <= valid_next;
      data_reg  <= data_next;
      chan_reg  <= chan_next;
    end
  end

  assign bus.sel       = sel_reg;
  assign bus.grant     = grant_reg;
  assign bus.out_valid = valid_reg;
  assign bus.out_data  = data_reg;
  assign bus.out_chan  = chan_reg;
endmodule

// File: tb/tb_mux_rr_scanner.sv
// Directed bench for mux_rr_scanner with a behavioural 6:1 mux feeding mux_data.
module tb_mux_rr_scanner;
  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   errs    = 0;
  logic [3:0] chan_data [6] = '{4'h3, 4'h7, 4'hA, 4'hC, 4'hE, 4'h1};

  mux_rr_scanner_if #(.DATA_W(4), .NCH(6)) bus ();

  mux_rr_scanner #(.DATA_W(4), .NCH(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.mux_data = (bus.sel < 3'd6) ? chan_data[bus.sel] : 4'h0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expect the SEL cycle for channel ch.
  task automatic sel_chk(input string tag, input int ch);
    logic [5:0] oh;
    oh = 6'd1 << ch;
    chk({tag, ".sel"}, 32'(bus.sel), 32'(ch));
    chk({tag, ".grant"}, 32'(bus.grant), 32'(oh));
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'd0);
  endtask

  // Expect a HOLD cycle presenting channel ch's word.
  task automatic hold_chk(input string tag, input int ch);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".chan"}, 32'(bus.out_chan), 32'(ch));
    chk({tag, ".data"}, 32'(bus.out_data), 32'(chan_data[ch]));
    chk({tag, ".grant"}, 32'(bus.grant), 32'd0);
    $display("word %s chan=%0d data=%h", tag, bus.out_chan, bus.out_data);
  endtask

  initial begin
    // Reset with random inputs
    reset         = 1'b1;
    bus.req       = 6'($urandom);
    bus.out_ready = 1'($urandom);
    tick();
    tick();
    chk("rst.sel", 32'(bus.sel), 32'd0);
    chk("rst.grant", 32'(bus.grant), 32'd0);
    chk("rst.valid", 32'(bus.out_valid), 32'd0);
    chk("rst.data", 32'(bus.out_data), 32'd0);
    chk("rst.chan", 32'(bus.out_chan), 32'd0);

    // First grant after reset goes to the lowest requester
    reset = 1'b0; bus.req = 6'b110100; bus.out_ready = 1'b0;
    tick(); sel_chk("first", 2);
    bus.req = 6'b000000;
    tick(); hold_chk("first", 2);
    bus.out_ready = 1'b1;
    tick(); chk("first.drop", 32'(bus.out_valid), 32'd0);

    // Single request; req dropped during SEL must not disturb capture
    bus.req = 6'b000100;
    tick(); sel_chk("single", 2);
    bus.req = 6'b000000;
    tick(); hold_chk("single", 2);
    tick(); chk("single.idle", 32'(bus.out_valid), 32'd0);
    tick(); chk("single.nogrant", 32'(bus.grant), 32'd0);

    // Full load from a fresh pointer: 0,1,2,3,4,5,0
    reset = 1'b1;
    tick();
    reset = 1'b0; bus.req = 6'h3F; bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick(); sel_chk("load", i % 6);
      tick(); hold_chk("load", i % 6);
    end

    // Backpressure in HOLD on channel 0
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      hold_chk("bp", 0);
      chk("bp.sel", 32'(bus.sel), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick(); sel_chk("bp.next", 1);
    tick(); hold_chk("bp.next", 1);

    // Continue to channel 5, then wrap
    for (int ch = 2; ch < 6; ch++) begin
      tick(); sel_chk("run", ch);
      tick(); hold_chk("run", ch);
    end
    bus.req = 6'b100001;
    tick(); sel_chk("wrap", 0);
    tick(); hold_chk("wrap", 0);
    tick(); sel_chk("wrap", 5);
    tick(); hold_chk("wrap", 5);

    // Reset mid-HOLD
    bus.req = 6'h3F; bus.out_ready = 1'b0;
    tick(); hold_chk("midhold", 5);
    reset = 1'b1;
    tick();
    chk("midrst.valid", 32'(bus.out_valid), 32'd0);
    chk("midrst.sel", 32'(bus.sel), 32'd0);
    reset = 1'b0; bus.req = 6'b110000; bus.out_ready = 1'b1;
    tick(); sel_chk("postrst", 4);
    bus.req = 6'b000000;
    tick(); hold_chk("postrst", 4);
    tick(); chk("postrst.idle", 32'(bus.out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/mux_rr_scanner.md
# mux_rr_scanner

Round-robin channel scanner that sits directly upstream of the 6:1 4-bit data mux. It arbitrates among per-channel requests and drives the mux select. It samples the mux result and presents it on a registered valid/ready output, tagged with the source channel. It is a three-state FSM with a round-robin pointer. The mux itself stays purely combinational and external.

## Interface
- DATA_W, 4, width of each channel word and of the mux result
- NCH, 6, number of channels scanned (1..8); select values >= NCH are never driven

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req  input  NCH  per-channel request; bit i = channel i has a word ready on mux input i
- mux_data  input  DATA_W  combinational output of the external mux (value of channel `sel`)
- sel  output  3  registered select to the external mux
- grant  output  NCH  one-hot, one-cycle acknowledge to the channel whose word is being sampled
- out_valid  output  1  out_data/out_chan hold a captured word
- out_data  output  DATA_W  captured word
- out_chan  output  3  channel index the word came from
- out_ready  input  1  downstream accepts the word when out_valid & out_ready

## Operation
- Reset values: state IDLE, sel=0, grant=0, out_valid=0, out_data=0, out_chan=0, pointer last=NCH-1. All outputs are registered.
- Arbitration: the winner is the first set bit of req scanning from (last+1) mod NCH upward, wrapping at NCH. `last` takes the winner's index when a winner is chosen. No request means no winner.
- State IDLE:
  - If req != 0, register sel = winner, set grant = one-hot(winner), and go to SEL.
  - Otherwise stay in IDLE, with sel holding its value and grant=0.
- State SEL (exactly one cycle):
  - grant is high for this cycle only.
  - External mux settles on sel. At the end of the cycle, capture out_data = mux_data and out_chan = sel, set out_valid=1, and go to HOLD.
  - req changes during SEL do not affect the capture.
- State HOLD:
  - out_valid=1. out_data and out_chan are stable, and sel is held.
  - If out_ready=0, stay in HOLD.
  - If out_ready=1 (handshake), out_valid drops next cycle. If req != 0 in the same cycle, register the new sel/grant and go to SEL. Otherwise go to IDLE.
- Channel contract: channel i keeps its mux input stable while grant[i]=1. It may update the data or drop req from the next cycle on. A channel that keeps req high with new data is served again in round-robin turn.
- Reset mid-operation: any captured or in-flight word is discarded and the pointer returns to NCH-1, so the next grant goes to the lowest requesting channel.

## Timing
- Latency: req seen in IDLE at cycle N. sel and grant are valid in cycle N+1 (SEL). out_valid rises in cycle N+2.
- Throughput: one word every 2 cycles with out_ready held high (HOLD → SEL → HOLD).
- out_valid is never high in SEL or IDLE, and is never high two cycles in a row across a handshake.
- Backpressure: holding out_ready low freezes the state, sel, out_data and out_chan indefinitely. No grant is issued while out_ready is low.
- Simultaneous requests: exactly one grant per SEL cycle. A requester waits at most NCH-1 other grants.
- Wrap-around: when last=NCH-1, the scan starts at channel 0.

## Test plan
- Reset check: assert reset 2 cycles with random inputs. Required: sel=0, grant=0, out_valid=0, out_data=0, out_chan=0. The first later grant goes to the lowest requesting channel.
- Single request: req=6'b000100 with channel 2 data = 4'hA. Required: sel=2 and grant=6'b000100 one cycle after; out_valid=1, out_data=4'hA, out_chan=2 the cycle after.
- Full load: req=6'h3F held, distinct data per channel, out_ready=1. Required: out_chan sequence 0,1,2,3,4,5,0, with out_valid on every second cycle.
- Backpressure: out_ready=0 for 5 cycles while in HOLD with req=6'h3F. Required: out_valid, out_data, out_chan and sel are constant and grant=0 throughout. On out_ready=1, the next grant goes to the next channel in round-robin order.
- Wrap: after serving channel 5, apply req=6'b100001. Required: grant order is 0 then 5.
- Reset mid-HOLD: reset during HOLD with out_ready=0. Required: out_valid=0 the next cycle. A subsequent req=6'b110000 is granted channel 4 first.
